// File: rtl/bist_session_ctrl.sv
// Initiator-side session controller for one LFSR/MISR BIST wrapper: runs clear/run/settle/check
// sessions, retries non-PASS verdicts and holds the final verdict until acknowledged.
module bist_session_ctrl #(
    parameter int PATTERNS  = 256,
    parameter int SETTLE    = 2,
    parameter int MAX_RETRY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        ack,
    input  logic [31:0] bist_result,
    output logic        bist_test,
    output logic        bist_en,
    output logic        bist_rst,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        invalid,
    output logic        aborted,
    output logic [1:0]  attempts
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int CNT_MAX = (PATTERNS > SETTLE) ? PATTERNS : SETTLE;
    localparam int CNT_W   = ($clog2(CNT_MAX + 1) > 9) ? $clog2(CNT_MAX + 1) : 9;

    localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(1);
    localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(PATTERNS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [1:0]       RETRY_LIM   = 2'(MAX_RETRY);

    localparam logic [31:0] CODE_PASS = 32'h50415353;
    localparam logic [31:0] CODE_FAIL = 32'h4641494C;

    localparam logic [1:0] V_PASS = 2'd0;
    localparam logic [1:0] V_FAIL = 2'd1;
    localparam logic [1:0] V_INV  = 2'd2;

    function automatic logic [1:0] decode_verdict(input logic [31:0] word);
        if (word == CODE_PASS)
            return V_PASS;
        else if (word == CODE_FAIL)
            return V_FAIL;
        else
            return V_INV;
    endfunction

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       vcode;

    assign vcode = decode_verdict(bist_result);

    // Abort takes priority over every timed transition, including the CHECK decision.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start && !abort) state_nxt = S_CLR;
            S_CLR:    if (abort) state_nxt = S_DONE;
                      else if (cnt == CLR_LAST) state_nxt = S_RUN;
            S_RUN:    if (abort) state_nxt = S_DONE;
                      else if (cnt == RUN_LAST) state_nxt = S_SETTLE;
            S_SETTLE: if (abort) state_nxt = S_DONE;
                      else if (cnt == SETTLE_LAST) state_nxt = S_CHECK;
            S_CHECK:  if (abort) state_nxt = S_DONE;
                      else if (vcode == V_PASS) state_nxt = S_DONE;
                      else if (attempts <= RETRY_LIM) state_nxt = S_CLR;
                      else state_nxt = S_DONE;
            S_DONE:   if (ack) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (state == S_CLR || state == S_RUN || state == S_SETTLE)
                cnt <= cnt + 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bist_test <= 1'b0;
            bist_en   <= 1'b0;
            bist_rst  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            bist_test <= (state_nxt == S_CLR) || (state_nxt == S_RUN) ||
                         (state_nxt == S_SETTLE) || (state_nxt == S_CHECK);
            bist_en   <= (state_nxt == S_RUN);
            bist_rst  <= (state_nxt == S_CLR);
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            attempts <= 2'd0;
        end else if (state == S_IDLE && state_nxt == S_CLR) begin
            attempts <= 2'd1;
        end else if (state == S_CHECK && state_nxt == S_CLR) begin
            attempts <= attempts + 2'd1;
        end
    end

    // Entering DONE from CLR/RUN/SETTLE is only possible through abort, so abort alone
    // distinguishes an aborted session from a decoded verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass    <= 1'b0;
            fail    <= 1'b0;
            invalid <= 1'b0;
            aborted <= 1'b0;
        end else if (state != S_DONE && state_nxt == S_DONE) begin
            aborted <= abort;
            pass    <= !abort && (vcode == V_PASS);
            fail    <= !abort && (vcode == V_FAIL);
            invalid <= !abort && (vcode == V_INV);
        end else if ((state == S_IDLE && state_nxt == S_CLR) ||
                     (state == S_DONE && state_nxt == S_IDLE)) begin
            pass    <= 1'b0;
            fail    <= 1'b0;
            invalid <= 1'b0;
            aborted <= 1'b0;
        end
    end

endmodule

// File: doc/bist_session_ctrl.md
# bist_session_ctrl

Initiator-side controller for the BIST wrapper (LFSR TPG → CUT → MISR → golden-signature compare). It drives the wrapper's `test`, `en` and `rst` inputs to run a complete test session, then reads back the 32-bit ASCII verdict word ("PASS"/"FAIL"). It retries failed sessions up to a limit and presents a latched verdict to the system through a start/done/ack handshake. It sits between the system sequencer and one BIST instance.

## Interface

**Parameters**
- `PATTERNS`, default 256: cycles `bist_en` is held high per session. Must be ≥ the wrapper's pattern count.
- `SETTLE`, default 2: wait cycles between end of RUN and result sampling. Must be ≥ 1.
- `MAX_RETRY`, default 2: extra sessions allowed after a non-PASS verdict. Range 0..2.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a session. Sampled only in IDLE.
- `abort` in 1: terminate the session in progress.
- `ack` in 1: consume the verdict. Sampled only in DONE.
- `bist_result` in 32: verdict word from the BIST wrapper.
- `bist_test` out 1: selects TPG patterns in the wrapper.
- `bist_en` out 1: TPG enable.
- `bist_rst` out 1: active-high reset to the wrapper.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: verdict valid. Held until `ack`.
- `pass` out 1: final verdict was 32'h50415353.
- `fail` out 1: final verdict was 32'h4641494C.
- `invalid` out 1: final word was neither code.
- `aborted` out 1: session ended by `abort`.
- `attempts` out 2: number of sessions run, 1..3.

## Operation

**States:** IDLE, CLR, RUN, SETTLE, CHECK, DONE. All outputs are registered.
- **IDLE:** `start`=1 and `abort`=0 → CLR. Clears `attempts` to 0 and all verdict flags.
- **CLR:** 2 cycles. `bist_rst`=1. Increments `attempts` on entry. → RUN.
- **RUN:** exactly PATTERNS cycles. `bist_en`=1. Uses a 9-bit-or-wider cycle counter. → SETTLE.
- **SETTLE:** SETTLE cycles. `bist_en`=0. → CHECK.
- **CHECK:** 1 cycle. Samples `bist_result` and decodes it.
  - PASS code → DONE with `pass`=1.
  - FAIL code or any other value: if `attempts` ≤ MAX_RETRY → CLR (retry); otherwise → DONE with `fail` or `invalid` set.
- **DONE:** `done`=1 and the verdict flags are held. `ack`=1 → IDLE, clearing `done`, `pass`, `fail`, `invalid` and `aborted`. `attempts` holds its value until the next start.

**Output rules**
- `bist_test`=1 in CLR, RUN, SETTLE and CHECK; 0 otherwise.
- `bist_rst`=0 outside CLR, so the wrapper's latched result stays readable.
- At most one of `pass`, `fail`, `invalid`, `aborted` is ever high.

**Boundary conditions**
- `abort` in CLR, RUN, SETTLE or CHECK → DONE next edge, with `aborted`=1, `bist_en`=0 and `bist_test`=0. Abort wins over a same-cycle CHECK decision.
- `abort` in IDLE or DONE is ignored. `start` and `abort` together in IDLE → stay in IDLE.
- `start` outside IDLE is ignored.
- `ack` outside DONE is ignored. `ack` and `start` in the same DONE cycle → IDLE only; `start` must be re-presented.
- `rst_n` low at any time, including mid-RUN:
  - Immediately: IDLE, `bist_rst`=1, every other output 0, counters cleared.
  - `bist_rst` falls on the first edge after `rst_n` deasserts.

## Timing

- **Reset values:** `bist_rst`=1; `bist_test`, `bist_en`, `busy`, `done`, `pass`, `fail`, `invalid`, `aborted` = 0; `attempts`=0.
- **`start` sampled at edge 0:**
  - `busy` and `bist_rst` are high after edge 0.
  - RUN begins after edge 2; `bist_en` is high for edges 2..2+PATTERNS-1.
  - CHECK begins after edge 2+PATTERNS+SETTLE.
  - `done` is high after edge 3+PATTERNS+SETTLE, i.e. 261 cycles with default parameters.
- **Per-attempt latency:** each retry adds 3+PATTERNS+SETTLE cycles (261 at defaults). `done` therefore appears at 261×N cycles for N sessions.
- **Abort latency:** `abort` high at edge k → `done` and `aborted` high after edge k.
- **Ack latency:** `ack` sampled at edge k → `done` low and `busy` low after edge k.
- **Result sampling:** `bist_result` must be stable during the CHECK cycle only.

## Test plan

1. **Reset:** hold `rst_n`=0 for 3 cycles, then release. Required: `bist_rst`=1 during reset and 0 after the first edge; all other outputs 0; `start` and `ack` ignored until reset is released.
2. **Single pass:** `start`, with `bist_result`=32'h50415353. Required: `bist_en` high for exactly 256 cycles; `done`=1 and `pass`=1 at cycle 261; `attempts`=1. Then `ack` → `busy`=0 on the next cycle.
3. **Fail then pass:** `bist_result`=32'h4641494C in the first CHECK and 32'h50415353 in the second. Required: `bist_rst` pulses twice; `done` at cycle 522; `pass`=1; `attempts`=2.
4. **Persistent bad word:** `bist_result`=32'h00000000 with MAX_RETRY=2. Required: `done` at cycle 783; `invalid`=1; `attempts`=3. Repeat with 32'h4641494C → `fail`=1.
5. **Abort and ignored inputs:** `abort` at RUN cycle 100. Required: next cycle `done`=1, `aborted`=1, `bist_en`=0. Also: `start` pulsed while busy changes nothing; `ack` together with `start` returns to IDLE without starting a new session.
6. **Reset mid-operation:** `rst_n` low during SETTLE. Required: outputs return to reset values asynchronously; a fresh `start` gives `done` at cycle 261.
